// File: rtl/navic_pkg.sv
// Shared types and constants for the NavIC PRN code-phase correlator.
package navic_pkg;

  localparam int unsigned CODE_LEN = 1023;
  localparam int unsigned LFSR_W   = 10;
  localparam int unsigned ACC_W    = 12;
  localparam int unsigned PHASE_W  = 10;
  localparam int unsigned CNT_W    = 10;

  // Bit i-1 marks stage i as a feedback tap.
  // G1 = x^10+x^3+1.
  localparam logic [LFSR_W-1:0] G1_TAPS = 10'b10_0000_0100;
  // G2 = x^10+x^9+x^8+x^6+x^3+x^2+1.
  localparam logic [LFSR_W-1:0] G2_TAPS = 10'b11_1010_0110;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ALIGN     = 3'd1,
    ST_INTEGRATE = 3'd2,
    ST_COMPARE   = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  typedef struct packed {
    logic [PHASE_W-1:0]      phase;
    logic signed [ACC_W-1:0] corr;
  } best_t;

  // Fibonacci shift: stage 1 takes the tap parity, stage i takes stage i-1.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s,
                                                  input logic [LFSR_W-1:0] taps);
    return {s[LFSR_W-2:0], ^(s & taps)};
  endfunction

endpackage

// File: rtl/navic_gold_gen.sv
// Gold-code replica: G1 and G2 LFSRs, reloadable to chip 0 (all-ones state).
module navic_gold_gen
  import navic_pkg::*;
#(
  parameter int unsigned G2_TAP_A = 2,
  parameter int unsigned G2_TAP_B = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic advance,
  output logic chip
);

  logic [LFSR_W-1:0] r_g1;
  logic [LFSR_W-1:0] r_g2;

  always_ff @(posedge clk) begin
    if (!rst_n || load) begin
      r_g1 <= '1;
      r_g2 <= '1;
    end else if (advance) begin
      r_g1 <= lfsr_step(r_g1, G1_TAPS);
      r_g2 <= lfsr_step(r_g2, G2_TAPS);
    end
  end

  // Current chip is a pure decode of the register state.
  assign chip = r_g1[LFSR_W-1] ^ r_g2[G2_TAP_A-1] ^ r_g2[G2_TAP_B-1];

endmodule

// File: rtl/navic_prn_correlator.sv
// Serial code-phase search: one full-code integration per trial phase,
// keeping the strictly largest correlation (ties keep the lowest phase).
module navic_prn_correlator
  import navic_pkg::*;
#(
  parameter int unsigned G2_TAP_A   = 2,
  parameter int unsigned G2_TAP_B   = 6,
  parameter int unsigned NUM_PHASES = 1023,
  parameter int unsigned THRESH     = 512
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               rx_chip,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               busy,
  output logic               done,
  output logic [PHASE_W-1:0] best_phase,
  output logic [ACC_W-1:0]   best_corr,
  output logic               detect
);

  localparam logic [PHASE_W-1:0]      LAST_PHASE = PHASE_W'(NUM_PHASES - 1);
  localparam logic [CNT_W-1:0]        LAST_CHIP  = CNT_W'(CODE_LEN - 1);
  localparam logic signed [ACC_W-1:0] THRESH_S   = ACC_W'(THRESH);
  localparam logic signed [ACC_W-1:0] CORR_MIN   = {1'b1, {(ACC_W-1){1'b0}}};

  state_e                  r_state;
  logic [PHASE_W-1:0]      r_p;
  logic [CNT_W-1:0]        r_cnt;
  logic signed [ACC_W-1:0] r_acc;
  best_t                   r_best;
  logic                    r_rx_ready;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_detect;

  logic                    w_chip;
  logic                    w_load;
  logic                    w_advance;
  logic                    w_accept;
  logic                    w_win;
  logic signed [ACC_W-1:0] w_acc_next;
  logic signed [ACC_W-1:0] w_best_next;

  // r_cnt counts ALIGN cycles (first one reloads) and then accepted chips.
  assign w_accept    = rx_valid & r_rx_ready;
  assign w_load      = (r_state == ST_ALIGN) && (r_cnt == '0);
  assign w_advance   = ((r_state == ST_ALIGN) && (r_cnt != '0)) || w_accept;
  assign w_acc_next  = (rx_chip == w_chip) ? r_acc + ACC_W'(1) : r_acc - ACC_W'(1);
  assign w_win       = $signed(r_acc) > $signed(r_best.corr);
  assign w_best_next = w_win ? r_acc : r_best.corr;

  navic_gold_gen #(
    .G2_TAP_A (G2_TAP_A),
    .G2_TAP_B (G2_TAP_B)
  ) u_gold (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_load),
    .advance (w_advance),
    .chip    (w_chip)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_p          <= '0;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_best.phase <= '0;
      r_best.corr  <= '0;
      r_rx_ready   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_detect     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_p          <= '0;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_best.phase <= '0;
            r_best.corr  <= CORR_MIN;
            r_detect     <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          if (r_cnt == r_p) begin
            r_cnt      <= '0;
            r_rx_ready <= 1'b1;
            r_state    <= ST_INTEGRATE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_INTEGRATE: begin
          if (w_accept) begin
            r_acc <= w_acc_next;
            if (r_cnt == LAST_CHIP) begin
              r_cnt      <= '0;
              r_rx_ready <= 1'b0;
              r_state    <= ST_COMPARE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        ST_COMPARE: begin
          if (w_win) begin
            r_best.phase <= r_p;
            r_best.corr  <= r_acc;
          end
          r_acc <= '0;
          r_cnt <= '0;
          // Detect uses the post-compare best so it is valid with done.
          if (r_p == LAST_PHASE) begin
            r_done   <= 1'b1;
            r_detect <= $signed(w_best_next) >= THRESH_S;
            r_state  <= ST_DONE;
          end else begin
            r_p     <= r_p + PHASE_W'(1);
            r_state <= ST_ALIGN;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rx_ready   = r_rx_ready;
  assign busy       = r_busy;
  assign done       = r_done;
  assign best_phase = r_best.phase;
  assign best_corr  = r_best.corr;
  assign detect     = r_detect;

endmodule

// File: tb/tb_navic_prn_correlator.sv
// Randomized bench for navic_prn_correlator against a correlation model.
module tb_navic_prn_correlator;

  localparam int N_LEN  = 1023;
  localparam int TAP_A  = 2;
  localparam int TAP_B  = 6;
  localparam int THR    = 512;
  localparam int M_ALIGN = 0;
  localparam int M_INV   = 1;
  localparam int M_ZERO  = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic start16, start8;
  logic rx_chip, rx_valid;
  logic rdy16, busy16, done16, det16;
  logic rdy8, busy8, done8, det8;
  logic [9:0]  bp16, bp8;
  logic [11:0] bc16, bc8;

  int n_checks = 0;
  int n_fail   = 0;
  bit code [N_LEN];

  always #5 clk = ~clk;

  navic_prn_correlator #(.G2_TAP_A(TAP_A), .G2_TAP_B(TAP_B), .NUM_PHASES(16), .THRESH(THR)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .rx_chip(rx_chip), .rx_valid(rx_valid),
    .rx_ready(rdy16), .busy(busy16), .done(done16), .best_phase(bp16), .best_corr(bc16),
    .detect(det16));

  navic_prn_correlator #(.G2_TAP_A(TAP_A), .G2_TAP_B(TAP_B), .NUM_PHASES(8), .THRESH(THR)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .rx_chip(rx_chip), .rx_valid(rx_valid),
    .rx_ready(rdy8), .busy(busy8), .done(done8), .best_phase(bp8), .best_corr(bc8),
    .detect(det8));

  task automatic check_val(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference Gold sequence, chip 0 from the all-ones registers.
  task automatic gen_code();
    bit g1 [1:10];
    bit g2 [1:10];
    bit f1, f2;
    for (int k = 1; k <= 10; k++) begin g1[k] = 1'b1; g2[k] = 1'b1; end
    for (int i = 0; i < N_LEN; i++) begin
      code[i] = g1[10] ^ g2[TAP_A] ^ g2[TAP_B];
      f1 = g1[3] ^ g1[10];
      f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
      for (int k = 10; k > 1; k--) begin g1[k] = g1[k-1]; g2[k] = g2[k-1]; end
      g1[1] = f1;
      g2[1] = f2;
    end
  endtask

  // Received chip at accepted sample j of every trial.
  function automatic bit stream_bit(input int mode, input int d, input int j);
    case (mode)
      M_ALIGN: return code[(j + d) % N_LEN];
      M_INV:   return !code[(j + d) % N_LEN];
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_best(input int mode, input int d, input int nph,
                            output int bphase, output int bcorr);
    bcorr  = -2048;
    bphase = 0;
    for (int p = 0; p < nph; p++) begin
      int a = 0;
      for (int j = 0; j < N_LEN; j++)
        a += (stream_bit(mode, d, j) == code[(p + j) % N_LEN]) ? 1 : -1;
      if (a > bcorr) begin bcorr = a; bphase = p; end
    end
  endtask

  task automatic set_start(input bit use8, input logic v);
    if (use8) start8 = v; else start16 = v;
  endtask

  task automatic check_outs(input string name, input bit use8, input int bp, input int bc,
                            input logic exp_det);
    check_val({name, ".best_phase"}, use8 ? bp8 : bp16, bp);
    check_val({name, ".best_corr"}, use8 ? $signed(bc8) : $signed(bc16), bc);
    check_val({name, ".detect"}, use8 ? det8 : det16, exp_det);
  endtask

  // Runs one search from the current (idle) cycle; optional mid-run reset.
  task automatic run_search(input string name, input bit use8, input int mode, input int d,
                            input int vlow_pct, input bit spur, input int abort_after);
    int  nph       = use8 ? 8 : 16;
    int  budget    = use8 ? 12000 : 40000;
    int  acc_total = 0;
    int  gap       = 0;
    int  gapsum    = 0;
    int  exp_gaps  = 0;
    int  bad_rdy   = 0;
    int  bp, bc, dones;
    bit  seen_high = 1'b0;
    bit  got_done  = 1'b0;
    bit  drv_valid = 1'b0;
    bit  rdy       = 1'b0;
    bit  bsy;
    model_best(mode, d, nph, bp, bc);
    for (int k = 1; k < nph; k++) exp_gaps += k + 2;
    set_start(use8, 1'b1);
    rx_valid = 1'b0;
    for (int cyc = 0; cyc < budget && !got_done; cyc++) begin
      @(posedge clk); #1;
      if (drv_valid && rdy) acc_total++;
      set_start(use8, 1'b0);
      rdy = use8 ? rdy8 : rdy16;
      bsy = use8 ? busy8 : busy16;
      if (abort_after > 0 && acc_total == abort_after) begin
        rx_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_val({name, ".busy_after_rst"}, use8 ? busy8 : busy16, 0);
        check_val({name, ".ready_after_rst"}, use8 ? rdy8 : rdy16, 0);
        check_val({name, ".corr_after_rst"}, use8 ? bc8 : bc16, 0);
        dones = 0;
        for (int w = 0; w < 16; w++) begin
          if (use8 ? done8 : done16) dones++;
          @(posedge clk); #1;
        end
        check_val({name, ".no_done"}, dones, 0);
        return;
      end
      if (rdy && !bsy) bad_rdy++;
      if (rdy) begin
        if (seen_high && gap > 0) gapsum += gap;
        gap = 0;
        seen_high = 1'b1;
      end else if (seen_high) begin
        gap++;
      end
      if (use8 ? done8 : done16) begin
        got_done = 1'b1;
        check_val({name, ".busy_in_done"}, bsy, 1);
        check_outs({name, "@done"}, use8, bp, bc, bc >= THR);
        if (spur) set_start(use8, 1'b1);
      end else if (spur && bsy && $urandom_range(99) < 2) begin
        set_start(use8, 1'b1);
      end
      drv_valid = ($urandom_range(99) >= vlow_pct);
      rx_valid  = drv_valid;
      rx_chip   = drv_valid ? stream_bit(mode, d, acc_total % N_LEN) : 1'($urandom_range(1));
    end
    check_val({name, ".finished"}, got_done, 1);
    rx_valid = 1'b0;
    @(posedge clk); #1;
    set_start(use8, 1'b0);
    check_val({name, ".single_done"}, use8 ? done8 : done16, 0);
    check_val({name, ".idle_after"}, use8 ? busy8 : busy16, 0);
    check_val({name, ".accepted"}, acc_total, nph * N_LEN);
    check_val({name, ".align_gaps"}, gapsum, exp_gaps);
    check_val({name, ".ready_only_busy"}, bad_rdy, 0);
    if (spur) begin
      repeat (10) @(posedge clk);
      #1;
      check_outs({name, "@hold"}, use8, bp, bc, bc >= THR);
      check_val({name, ".still_idle"}, use8 ? busy8 : busy16, 0);
    end
  endtask

  initial begin
    gen_code();
    rst_n = 1'b0; start16 = 1'b0; start8 = 1'b0; rx_valid = 1'b0; rx_chip = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst16.busy", busy16, 0);
    check_val("rst16.done", done16, 0);
    check_val("rst16.ready", rdy16, 0);
    check_outs("rst16", 1'b0, 0, 0, 1'b0);
    check_val("rst8.busy", busy8, 0);
    check_val("rst8.ready", rdy8, 0);
    check_outs("rst8", 1'b1, 0, 0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_search("aligned", 1'b0, M_ALIGN, 5, 0, 1'b0, 0);
    run_search("abort", 1'b0, M_ALIGN, 5, 0, 1'b0, 3 * N_LEN + 500);
    run_search("gappy", 1'b0, M_ALIGN, 5, 40, 1'b1, 0);
    run_search("inverted", 1'b1, M_INV, 5, 0, 1'b0, 0);
    run_search("zeros", 1'b1, M_ZERO, 0, 0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/navic_prn_correlator.md
NAVIC_PRN_CORRELATOR -- requirements
Module: navic_prn_correlator

Interface
REQ-001 SHALL have parameter G2_TAP_A, default 2, meaning the first G2 tap (1..10) that selects the PRN.
REQ-002 SHALL have parameter G2_TAP_B, default 6, meaning the second G2 tap (1..10).
REQ-003 SHALL have parameter NUM_PHASES, default 1023, meaning the number of code phases searched (1..1023).
REQ-004 SHALL have parameter THRESH, default 512, meaning the minimum best_corr that asserts detect.
REQ-005 SHALL have ports, in order:
  - clk  in  1  system clock, rising edge
  - rst_n  in  1  synchronous, active-low reset
  - start  in  1  1-cycle pulse that begins a search
  - rx_chip  in  1  received hard chip (1 = +1, 0 = -1)
  - rx_valid  in  1  rx_chip is valid
  - rx_ready  out  1  block accepts rx_chip this cycle
  - busy  out  1  search in progress
  - done  out  1  1-cycle pulse when the search completes
  - best_phase  out  10  code phase with the maximum correlation
  - best_corr  out  12  signed maximum correlation
  - detect  out  1  best_corr >= THRESH, valid from done

Function
REQ-006 SHALL generate a 1023-chip Gold replica:
  - G1 = x^10+x^3+1; G2 = x^10+x^9+x^8+x^6+x^3+x^2+1; both start all-ones.
  - Chip = G1[10] xor G2[G2_TAP_A] xor G2[G2_TAP_B].
  - Chip 0 is the output of the all-ones state.
REQ-007 SHALL implement the FSM IDLE -> ALIGN -> INTEGRATE -> COMPARE, then back to ALIGN, or to DONE -> IDLE.
REQ-008 IDLE: start=1 SHALL do all of the following:
  - clear the phase counter p and the trial accumulator;
  - set best_corr to -2048 and best_phase to 0;
  - move to ALIGN.
REQ-009 ALIGN: SHALL reload the replica to chip 0, then advance it one chip per cycle for p cycles, then enter INTEGRATE; ALIGN SHALL last p+1 cycles.
REQ-010 INTEGRATE: rx_ready SHALL be 1.
  - On each cycle with rx_valid & rx_ready, acc SHALL add +1 when rx_chip equals the replica chip and -1 otherwise, and the replica SHALL advance one chip.
  - Cycles without rx_valid SHALL change nothing.
REQ-011 INTEGRATE SHALL exit to COMPARE after exactly 1023 accepted chips; acc range is -1023..+1023 in 12-bit two's complement, with no saturation.
REQ-012 COMPARE (1 cycle) SHALL do all of the following:
  - If acc > best_corr (strict), load best_corr=acc and best_phase=p, so ties keep the lowest phase.
  - Clear acc.
  - If p = NUM_PHASES-1, go to DONE; otherwise increment p and go to ALIGN.
REQ-013 DONE (1 cycle) SHALL assert done=1 and register detect = (best_corr >= THRESH), then return to IDLE.
REQ-014 busy SHALL be 1 in every state except IDLE; rx_ready SHALL be 0 outside INTEGRATE.
REQ-015 start SHALL be ignored while busy=1. A start in the DONE cycle SHALL be ignored; a start on the first IDLE cycle after DONE SHALL be accepted.
REQ-016 best_phase, best_corr and detect SHALL hold their values from DONE until the next accepted start.
REQ-017 Phase semantics: if the rx stream carries chip (j+d) mod 1023 at accepted sample j of each trial, phase p=d SHALL produce acc=+1023.

Reset
REQ-018 When rst_n=0 at a clock edge, the block SHALL do all of the following regardless of state:
  - state=IDLE, p=0, acc=0;
  - G1 and G2 all-ones;
  - busy=0, done=0, rx_ready=0, detect=0, best_phase=0, best_corr=0.
REQ-019 A reset during ALIGN, INTEGRATE or COMPARE SHALL abort the search with no done pulse.

Structure
REQ-020 A shared package navic_pkg SHALL hold:
  - the FSM state enum;
  - CODE_LEN=1023;
  - the G1 and G2 polynomial tap constants;
  - the accumulator width constant (12).
REQ-021 The replica SHALL be a sub-module navic_gold_gen with ports clk, rst_n, load, advance, chip, parameterised by G2_TAP_A and G2_TAP_B.

Verification
REQ-022 Aligned stream, NUM_PHASES=16: rx = replica delayed so that d=5 -> best_phase=5, best_corr=+1023, detect=1, one done pulse.
REQ-023 All-zero rx, NUM_PHASES=8 -> every trial acc=-1, best_phase=0 (tie rule), best_corr=-1, detect=0.
REQ-024 Same stream as REQ-022 with rx_valid pseudo-randomly low about 40% of cycles -> identical results; rx_ready=0 throughout ALIGN and COMPARE.
REQ-025 Reset asserted mid-INTEGRATE of trial 3 -> next cycle busy=0, rx_ready=0, best_corr=0, and no done pulse; a new start afterwards completes normally.
REQ-026 start pulsed during busy and in the DONE cycle -> ignored; exactly one done per accepted start; best outputs stable after DONE.
REQ-027 Inverted aligned stream (d=5) -> best_corr <= 65, acc=-1023 at p=5, detect=0.
